instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Assembles instruction requests (kind, rs, rt, rd, imm) into 32-bit words in the
//  format the control decoder consumes, buffers them in a small FIFO and writes
//  them sequentially into instruction memory from BASE_ADDR upward.
//  Serves as the program loader in front of imem and in self-checking benches.
// PARAMETERS
//  ADDR_W     8   imem word-address width
//  DEPTH      4   FIFO entries (power of 2, >=2)
//  BASE_ADDR  0   first imem address written after start
// PORTS
//  clk          in   1       clock; all state changes on rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       begin a load session (accepted in IDLE or DONE only)
//  in_valid     in   1       request valid
//  in_ready     out  1       request accepted when in_valid & in_ready
//  in_kind      in   3       0 LW,1 SW,2 ADD,3 SUB,4 MUL,5 AND,6 OR,7 NOP
//  in_rs        in   5       source register
//  in_rt        in   5       second source / LW destination
//  in_rd        in   5       arith destination (ignored for LW/SW/NOP)
//  in_imm       in   16      LW/SW offset (ignored otherwise)
//  in_last      in   1       marks final instruction of the program
//  imem_we      out  1       write strobe (= FIFO non-empty in LOAD)
//  imem_ready   in   1       memory accepts write this cycle
//  imem_addr    out  ADDR_W  write address
//  imem_wdata   out  32      encoded instruction
//  busy         out  1       state == LOAD
//  done         out  1       state == DONE (held)
//  count        out  ADDR_W+1 instructions written this session
//  err_overflow out  1       sticky: entry dropped because address space exhausted
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, imem_addr=BASE_ADDR, count=0; in_ready, imem_we,
//   busy, done, err_overflow=0; imem_wdata=0. rst mid-LOAD discards FIFO content.
//  Encoding (registered at push): LW {6'd8,rs,rt,imm}; SW {6'd9,rs,rt,imm};
//   arith {6'd7,rs,rt,rd,5'd0,funct}, funct ADD 32, SUB 34, MUL 50, AND 36, OR 37;
//   NOP 32'h0000_0000 (decoder default path). Last flag stored alongside word.
//  FSM: IDLE -start-> LOAD (addr=BASE_ADDR, count=0, err_overflow=0);
//   LOAD -write of entry flagged last-> DONE; DONE -start-> LOAD (same init).
//   start while LOAD ignored.
//  in_ready = LOAD & !full & !last_taken (last_taken set on push of last entry,
//   cleared on entering LOAD). Push and pop may occur the same cycle; in_ready
//   depends on full only (no combinational pass-through).
//  Latency: word accepted into empty FIFO is on imem_wdata/imem_we next cycle.
//  Write handshake: imem_we & imem_ready pops head, count+1, addr+1. imem_we,
//   addr, wdata hold stable while imem_ready=0.
//  Address end: after a write at addr 2**ADDR_W-1 the address space is exhausted;
//   later entries are popped with imem_we=0 (no write, count unchanged) and
//   err_overflow set. A dropped entry flagged last still moves FSM to DONE.
//  count width ADDR_W+1 so 2**ADDR_W writes are representable.
// TESTING
//  1 start; push LW rs=1 rt=2 imm=16'h0004 last -> addr0=32'h2022_0004, done, count=1.
//  2 Push ADD(1,2,3),SUB,MUL,AND,OR(1,2,3) -> 1C221820,1C221822,1C221832,1C221824,1C221825.
//  3 imem_ready=0 for 10 cycles, push 5 -> in_ready low after DEPTH=4, bus held stable.
//  4 ADDR_W=2, push 5 entries, last on 5th -> 4 writes, err_overflow=1, done, count=4.
//  5 rst asserted mid-LOAD with 3 queued -> next cycle IDLE, imem_we=0, count=0.
//  6 start in DONE after test 1 -> LOAD, addr=BASE_ADDR, NOP written as 32'h0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes instruction requests, buffers them in a small FIFO and
// streams them into instruction memory from BASE_ADDR upward.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ABASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] AMAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [32:0]       mem_q [DEPTH];
  logic [PW:0]       wptr_q, rptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q, last_taken_q, exh_q;

  logic        load, empty, full, push, pop, wr, init;
  logic [32:0] head;
  logic [31:0] enc_word;
  logic [5:0]  funct;

  always_comb begin
    funct = 6'd32;
    unique case (in_kind)
      3'd3:    funct = 6'd34;
      3'd4:    funct = 6'd50;
      3'd5:    funct = 6'd36;
      3'd6:    funct = 6'd37;
      default: funct = 6'd32;
    endcase
  end

  always_comb begin
    enc_word = '0;
    unique case (in_kind)
      3'd0:    enc_word = {6'd8, in_rs, in_rt, in_imm};
      3'd1:    enc_word = {6'd9, in_rs, in_rt, in_imm};
      3'd7:    enc_word = '0;
      default: enc_word = {6'd7, in_rs, in_rt, in_rd, 5'd0, funct};
    endcase
  end

  assign load  = (state_q == S_LOAD);
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW] != rptr_q[PW]) &&
                 (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign head  = mem_q[rptr_q[PW-1:0]];

  assign in_ready = load & ~full & ~last_taken_q;
  assign push     = in_valid & in_ready;
  assign imem_we  = load & ~empty & ~exh_q;
  assign wr       = imem_we & imem_ready;
  // once the address space is used up, entries drain without a write
  assign pop      = load & ~empty & (exh_q | imem_ready);
  assign init     = start & ~load;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (pop && head[32]) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      addr_q       <= ABASE;
      count_q      <= '0;
      err_q        <= 1'b0;
      last_taken_q <= 1'b0;
      exh_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (init) begin
        wptr_q       <= '0;
        rptr_q       <= '0;
        addr_q       <= ABASE;
        count_q      <= '0;
        err_q        <= 1'b0;
        last_taken_q <= 1'b0;
        exh_q        <= 1'b0;
      end else begin
        if (push) begin
          wptr_q <= wptr_q + (PW+1)'(1);
          if (in_last) last_taken_q <= 1'b1;
        end
        if (pop) rptr_q <= rptr_q + (PW+1)'(1);
        if (wr) begin
          count_q <= count_q + (ADDR_W+1)'(1);
          addr_q  <= addr_q + ADDR_W'(1);
          if (addr_q == AMAX) exh_q <= 1'b1;
        end
        if (pop && exh_q) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[PW-1:0]] <= {in_last, enc_word};
  end

  assign imem_addr    = addr_q;
  assign imem_wdata   = empty ? 32'h0 : head[31:0];
  assign busy         = load;
  assign done         = (state_q == S_DONE);
  assign count        = count_q;
  assign err_overflow = err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed spec vectors plus a random
// stream checked against an encoding model and write scoreboard.
module tb_instr_encoder_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start2 = 1'b0;
  logic valid1 = 1'b0, valid2 = 1'b0;
  logic [2:0] kind = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic last = 1'b0;
  logic imem_ready = 1'b1;

  logic ready1, we1, busy1, done1, err1;
  logic [7:0] addr1;
  logic [31:0] wdata1;
  logic [8:0] count1;
  logic ready2, we2, busy2, done2, err2;
  logic [1:0] addr2;
  logic [31:0] wdata2;
  logic [2:0] count2;

  int tests = 0;
  int fails = 0;
  int exp_addr = 0;
  bit rand_ready = 1'b0;
  logic [31:0] q[$];
  logic [31:0] wr[$];

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(valid1),
    .in_ready(ready1), .in_kind(kind), .in_rs(rs), .in_rt(rt),
    .in_rd(rd), .in_imm(imm), .in_last(last), .imem_we(we1),
    .imem_ready(imem_ready), .imem_addr(addr1), .imem_wdata(wdata1),
    .busy(busy1), .done(done1), .count(count1), .err_overflow(err1));

  instr_encoder_loader #(.ADDR_W(2), .DEPTH(4), .BASE_ADDR(0)) u2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(valid2),
    .in_ready(ready2), .in_kind(kind), .in_rs(rs), .in_rt(rt),
    .in_rd(rd), .in_imm(imm), .in_last(last), .imem_we(we2),
    .imem_ready(imem_ready), .imem_addr(addr2), .imem_wdata(wdata2),
    .busy(busy2), .done(done2), .count(count2), .err_overflow(err2));

  function automatic logic [31:0] enc(input logic [2:0] k,
    input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
    input logic [15:0] im);
    logic [5:0] ft [8];
    ft = '{6'd0, 6'd0, 6'd32, 6'd34, 6'd50, 6'd36, 6'd37, 6'd0};
    if (k == 3'd0) return {6'd8, s, t, im};
    if (k == 3'd1) return {6'd9, s, t, im};
    if (k == 3'd7) return 32'h0;
    return {6'd7, s, t, d, 5'd0, ft[k]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && we1 && imem_ready) begin
      chk("write_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        chk("wdata", 64'(wdata1), 64'(q.pop_front()));
        chk("waddr", 64'(addr1), 64'(exp_addr));
      end
      wr.push_back(wdata1);
      exp_addr++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) imem_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit s2);
    if (s2) start2 = 1'b1;
    else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
    if (!s2) exp_addr = 0;
  endtask

  task automatic push(input bit s2, input logic [2:0] k,
    input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
    input logic [15:0] im, input logic l);
    int n;
    kind = k; rs = s; rt = t; rd = d; imm = im; last = l;
    if (s2) valid2 = 1'b1;
    else valid1 = 1'b1;
    n = 0;
    while (!(s2 ? ready2 : ready1) && n < 200) begin
      tick();
      n++;
    end
    chk("push_timeout", 64'(n < 200), 64'd1);
    @(posedge clk);
    if (!s2) q.push_back(enc(k, s, t, d, im));
    #1;
    valid1 = 1'b0;
    valid2 = 1'b0;
    last = 1'b0;
  endtask

  task automatic wait_done(input bit s2);
    int n;
    n = 0;
    while (!(s2 ? done2 : done1) && n < 2000) begin
      tick();
      n++;
    end
    chk("done_timeout", 64'(n < 2000), 64'd1);
  endtask

  initial begin
    int acc;
    logic [2:0] k;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ready", 64'(ready1), 64'd0);
    chk("rst_we", 64'(we1), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_done", 64'(done1), 64'd0);
    chk("rst_count", 64'(count1), 64'd0);
    chk("rst_err", 64'(err1), 64'd0);
    chk("rst_wdata", 64'(wdata1), 64'd0);
    chk("rst_addr", 64'(addr1), 64'd0);
    rst = 1'b0;
    tick();

    // LW single instruction program
    do_start(1'b0);
    chk("t1_busy", 64'(busy1), 64'd1);
    wr.delete();
    push(1'b0, 3'd0, 5'd1, 5'd2, 5'd0, 16'h0004, 1'b1);
    wait_done(1'b0);
    chk("t1_count", 64'(count1), 64'd1);
    chk("t1_nwr", 64'(wr.size()), 64'd1);
    if (wr.size() > 0) chk("t1_word", 64'(wr[0]), 64'h2022_0004);

    // restart from DONE, NOP encodes to zero
    do_start(1'b0);
    chk("t6_busy", 64'(busy1), 64'd1);
    chk("t6_addr", 64'(addr1), 64'd0);
    chk("t6_count", 64'(count1), 64'd0);
    wr.delete();
    push(1'b0, 3'd7, 5'd9, 5'd9, 5'd9, 16'hffff, 1'b1);
    wait_done(1'b0);
    chk("t6_nwr", 64'(wr.size()), 64'd1);
    if (wr.size() > 0) chk("t6_word", 64'(wr[0]), 64'h0);

    // arithmetic encodings
    do_start(1'b0);
    wr.delete();
    for (int i = 0; i < 5; i++)
      push(1'b0, 3'(i + 2), 5'd1, 5'd2, 5'd3, 16'h1234, 1'(i == 4));
    wait_done(1'b0);
    chk("t2_count", 64'(count1), 64'd5);
    chk("t2_nwr", 64'(wr.size()), 64'd5);
    if (wr.size() == 5) begin
      chk("t2_add", 64'(wr[0]), 64'h1C22_1820);
      chk("t2_sub", 64'(wr[1]), 64'h1C22_1822);
      chk("t2_mul", 64'(wr[2]), 64'h1C22_1832);
      chk("t2_and", 64'(wr[3]), 64'h1C22_1824);
      chk("t2_or", 64'(wr[4]), 64'h1C22_1825);
    end

    // backpressure: FIFO fills, bus holds
    imem_ready = 1'b0;
    do_start(1'b0);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      kind = 3'(2 + acc % 5); rs = 5'(acc); rt = 5'(acc + 7);
      rd = 5'(acc + 11); imm = '0; last = 1'b0;
      valid1 = 1'b1;
      if (ready1) begin
        @(posedge clk);
        q.push_back(enc(kind, rs, rt, rd, imm));
        #1;
        acc++;
      end else tick();
      if (i >= 2) begin
        chk("t3_hold_we", 64'(we1), 64'd1);
        chk("t3_hold_addr", 64'(addr1), 64'd0);
        chk("t3_hold_data", 64'(wdata1), 64'(q[0]));
      end
    end
    chk("t3_accepted", 64'(acc), 64'd4);
    chk("t3_ready_low", 64'(ready1), 64'd0);
    valid1 = 1'b0;
    imem_ready = 1'b1;
    push(1'b0, 3'd5, 5'd4, 5'd5, 5'd6, 16'h0, 1'b1);
    wait_done(1'b0);
    chk("t3_count", 64'(count1), 64'd5);
    chk("t3_q_empty", 64'(q.size()), 64'd0);

    // random program with random memory backpressure
    do_start(1'b0);
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      k = 3'($urandom_range(0, 7));
      push(1'b0, k, 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 1'(i == 39));
    end
    wait_done(1'b0);
    rand_ready = 1'b0;
    imem_ready = 1'b1;
    chk("rnd_count", 64'(count1), 64'd40);
    chk("rnd_q_empty", 64'(q.size()), 64'd0);
    chk("rnd_err", 64'(err1), 64'd0);

    // reset mid-load discards queued entries
    do_start(1'b0);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(1'b0, 3'd2, 5'(i), 5'd1, 5'd2, 16'h0, 1'b0);
    chk("t5_we_before", 64'(we1), 64'd1);
    rst = 1'b1;
    tick();
    chk("t5_busy", 64'(busy1), 64'd0);
    chk("t5_we", 64'(we1), 64'd0);
    chk("t5_count", 64'(count1), 64'd0);
    chk("t5_done", 64'(done1), 64'd0);
    q.delete();
    rst = 1'b0;
    imem_ready = 1'b1;
    tick();

    // address exhaustion on the 2-bit instance
    do_start(1'b1);
    for (int i = 0; i < 5; i++)
      push(1'b1, 3'd2, 5'(i), 5'd1, 5'd2, 16'h0, 1'(i == 4));
    wait_done(1'b1);
    chk("t4_count", 64'(count2), 64'd4);
    chk("t4_err", 64'(err2), 64'd1);
    chk("t4_done", 64'(done2), 64'd1);
    chk("t4_we", 64'(we2), 64'd0);
    chk("t4_u1_idle", 64'(busy1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
